// File: rtl/pc_unit_ras.sv
// Program-counter unit with return-address stack for the MIPS datapath.
// Selects the next PC from sequential, branch, jump, register, call,
// return, exception and exception-return sources. Calls push their
// return address onto a circular stack, returns pop it, and the PC of a
// faulting instruction is kept in epc. Register-sourced targets are
// forced to word alignment, and a misaligned source raises a flag pulse.
module pc_unit_ras #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'('h80),
  parameter int                RAS_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [2:0]        pc_control,
  input  logic              branch_taken,
  input  logic [25:0]       jump_address,
  input  logic [15:0]       branch_offset,
  input  logic [ADDR_W-1:0] reg_address,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] epc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_miss,
  output logic              misaligned
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    OP_SEQ  = 3'b000,
    OP_BR   = 3'b001,
    OP_J    = 3'b010,
    OP_JR   = 3'b011,
    OP_JAL  = 3'b100,
    OP_RET  = 3'b101,
    OP_EXC  = 3'b110,
    OP_ERET = 3'b111
  } op_t;

  // Sign-extend a 16-bit word offset to a byte offset of ADDR_W bits.
  function automatic logic [ADDR_W-1:0] word_offset(input logic signed [15:0] off);
    logic signed [ADDR_W-1:0] ext;
    ext = {{(ADDR_W-16){off[15]}}, off};
    return ext <<< 2;
  endfunction

  // Force a register-sourced target onto a word boundary.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

  op_t               op;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] reg_target;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top;
  logic [PTR_W-1:0]  top_prev;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] next_pc;
  logic              do_push;
  logic              do_pop;
  logic              do_exc;
  logic              miss_next;
  logic              mis_next;
  logic              advance;

  assign op            = op_t'(pc_control);
  assign pc_plus4      = pc + ADDR_W'(4);
  assign jump_target   = {pc_plus4[ADDR_W-1:28], jump_address, 2'b00};
  assign branch_target = pc_plus4 + word_offset(branch_offset);
  assign reg_target    = word_align(reg_address);
  // top is the next free slot; the most recent entry sits one below it.
  assign top_prev      = top - PTR_W'(1);
  assign ras_empty     = (count == '0);
  assign ras_full      = (count == CNT_MAX);
  assign advance       = ~stall;

  // Next-PC selection and stack/epc side effects for the current op.
  always_comb begin
    next_pc   = pc_plus4;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_exc    = 1'b0;
    miss_next = 1'b0;
    mis_next  = 1'b0;
    unique case (op)
      OP_SEQ: next_pc = pc_plus4;
      OP_BR: begin
        if (branch_taken) next_pc = branch_target;
      end
      OP_J: next_pc = jump_target;
      OP_JR: begin
        next_pc  = reg_target;
        mis_next = |reg_address[1:0];
      end
      OP_JAL: begin
        next_pc = jump_target;
        do_push = 1'b1;
      end
      OP_RET: begin
        if (!ras_empty) begin
          next_pc = ras_mem[top_prev];
          do_pop  = 1'b1;
        end else begin
          next_pc   = reg_target;
          miss_next = 1'b1;
          mis_next  = |reg_address[1:0];
        end
      end
      OP_EXC: begin
        next_pc = EXC_VECTOR;
        do_exc  = 1'b1;
      end
      OP_ERET: next_pc = epc;
      default: next_pc = pc_plus4;
    endcase
  end

  // PC, epc, stack bookkeeping and status pulses; reset wins over stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_VECTOR;
      epc        <= '0;
      top        <= '0;
      count      <= '0;
      ras_miss   <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      ras_miss   <= miss_next & advance;
      misaligned <= mis_next & advance;
      if (advance) begin
        pc <= next_pc;
        if (do_exc) epc <= pc;
        if (do_push) begin
          top <= top + PTR_W'(1);
          if (!ras_full) count <= count + CNT_W'(1);
        end else if (do_pop) begin
          top   <= top_prev;
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  // Stack storage: a push when full lands on the oldest slot and overwrites it.
  always_ff @(posedge clk) begin
    if (!rst && advance && do_push) ras_mem[top] <= pc_plus4;
  end

endmodule
